// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round controller.
// The optional key-length feature is enabled with macro AES_ROUND_CTRL_KEYLEN_EN.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } ctrl_state_e;

  localparam int AES_DATA_W = 128;

  localparam int AES_NR_128 = 10;
  localparam int AES_NR_192 = 12;
  localparam int AES_NR_256 = 14;

  localparam logic [1:0] KEYLEN_128  = 2'b00;
  localparam logic [1:0] KEYLEN_192  = 2'b01;
  localparam logic [1:0] KEYLEN_256  = 2'b10;
  localparam logic [1:0] KEYLEN_RSVD = 2'b11;

  // Reserved encoding falls back to the AES-128 round count.
  function automatic int keylen_rounds(input logic [1:0] kl);
    case (kl)
      KEYLEN_128: return AES_NR_128;
      KEYLEN_192: return AES_NR_192;
      KEYLEN_256: return AES_NR_256;
      default:    return AES_NR_128;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// Sequences one AES block through an external round datapath, one round per issue.
// Macro AES_ROUND_CTRL_KEYLEN_EN adds key_len and a per-block round count (10/12/14).
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int DATA_W = AES_DATA_W,
  parameter int NR     = 10,
  parameter int RND_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              blk_valid,
  output logic              blk_ready,
  input  logic [DATA_W-1:0] blk_data,
  output logic [RND_W-1:0]  rk_idx,
  input  logic [DATA_W-1:0] rk_data,
  output logic              dp_valid,
  output logic [DATA_W-1:0] dp_data,
  output logic              dp_mix_en,
  input  logic              dp_valid_in,
  input  logic [DATA_W-1:0] dp_data_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              busy,
`ifdef AES_ROUND_CTRL_KEYLEN_EN
  input  logic [1:0]        key_len,
`endif
  output logic              err
);

  localparam logic [RND_W-1:0] RND_ONE = RND_W'(1);

  ctrl_state_e       state_r;
  logic [RND_W-1:0]  rnd_r;
  logic [DATA_W-1:0] state_reg_r;
  logic              blk_ready_r;
  logic              dp_valid_r;
  logic              dp_mix_en_r;
  logic              res_valid_r;
  logic              busy_r;
  logic              err_r;

  logic [RND_W-1:0]  acc_last_s;
  logic [RND_W-1:0]  last_rnd_s;
  logic [RND_W-1:0]  rnd_next_s;
  logic              acc_err_s;

`ifdef AES_ROUND_CTRL_KEYLEN_EN
  logic [RND_W-1:0]  last_r;

  // Final round index for a block accepted this cycle, from key_len.
  always_comb begin
    acc_last_s = RND_W'(keylen_rounds(key_len));
    acc_err_s  = (key_len == KEYLEN_RSVD);
  end

  // Final-round compare uses the value sampled at accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_r <= RND_W'(AES_NR_128);
    end else if ((state_r == IDLE) && blk_valid) begin
      last_r <= acc_last_s;
    end
  end

  assign last_rnd_s = last_r;
`else
  // Fixed round count when the key-length feature is compiled out.
  always_comb begin
    acc_last_s = RND_W'(NR);
    acc_err_s  = 1'b0;
  end

  assign last_rnd_s = acc_last_s;
`endif

  assign rnd_next_s = rnd_r + RND_ONE;

  // Key index is zero while idle so rk_data carries the whitening key.
  always_comb begin
    if (state_r == IDLE) begin
      rk_idx = {RND_W{1'b0}};
    end else begin
      rk_idx = rnd_r;
    end
  end

  // Controller FSM with all handshake outputs registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      rnd_r       <= {RND_W{1'b0}};
      state_reg_r <= {DATA_W{1'b0}};
      blk_ready_r <= 1'b1;
      dp_valid_r  <= 1'b0;
      dp_mix_en_r <= 1'b0;
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      dp_valid_r <= 1'b0;
      if (dp_valid_in && (state_r != WAIT)) begin
        err_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (blk_valid) begin
            state_reg_r <= blk_data ^ rk_data;
            rnd_r       <= RND_ONE;
            state_r     <= ISSUE;
            dp_valid_r  <= 1'b1;
            dp_mix_en_r <= (acc_last_s != RND_ONE);
            blk_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            if (acc_err_s) begin
              err_r <= 1'b1;
            end
          end
        end
        ISSUE: begin
          state_r <= WAIT;
        end
        WAIT: begin
          if (dp_valid_in) begin
            state_reg_r <= dp_data_in;
            if (rnd_r == last_rnd_s) begin
              state_r     <= DONE;
              res_valid_r <= 1'b1;
            end else begin
              rnd_r       <= rnd_next_s;
              state_r     <= ISSUE;
              dp_valid_r  <= 1'b1;
              dp_mix_en_r <= (rnd_next_s != last_rnd_s);
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            state_r     <= IDLE;
            rnd_r       <= {RND_W{1'b0}};
            res_valid_r <= 1'b0;
            blk_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          rnd_r       <= {RND_W{1'b0}};
          res_valid_r <= 1'b0;
          blk_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign blk_ready = blk_ready_r;
  assign dp_valid  = dp_valid_r;
  assign dp_data   = state_reg_r;
  assign dp_mix_en = dp_mix_en_r;
  assign res_valid = res_valid_r;
  assign res_data  = state_reg_r;
  assign busy      = busy_r;
  assign err       = err_r;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: behavioural AES datapath/key schedule plus reference cipher.
// Define AES_ROUND_CTRL_KEYLEN_EN to include the key-length scenarios.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         blk_valid, blk_ready, dp_valid, dp_mix_en, dp_valid_in;
  logic         res_valid, res_ready, busy, err;
  logic [127:0] blk_data, rk_data, dp_data, dp_data_in, res_data;
  logic [3:0]   rk_idx;
`ifdef AES_ROUND_CTRL_KEYLEN_EN
  logic [1:0]   key_len;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0]   sbox [256];
  logic [127:0] rk   [16];
  int           lat_cfg = 1;
  int           nr_exp  = 10;
  logic         model_v, spur_v;
  logic [127:0] model_d, spur_d;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

  assign dp_valid_in = model_v | spur_v;
  assign dp_data_in  = spur_v ? spur_d : model_d;
  assign rk_data     = rk[rk_idx];

  aes_round_ctrl #(.DATA_W(128), .NR(10), .RND_W(4)) dut (
    .clk(clk), .reset(reset),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .rk_idx(rk_idx), .rk_data(rk_data),
    .dp_valid(dp_valid), .dp_data(dp_data), .dp_mix_en(dp_mix_en),
    .dp_valid_in(dp_valid_in), .dp_data_in(dp_data_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy),
`ifdef AES_ROUND_CTRL_KEYLEN_EN
    .key_len(key_len),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One full AES round on a 128-bit state: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic mix, input logic [127:0] k);
    logic [7:0] a [16];
    logic [7:0] t [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r+4*c] = a[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      if (mix) begin
        a[4*c+0] = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
        a[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
        a[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
        a[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
      end else begin
        for (int r = 0; r < 4; r++) a[4*c+r] = t[4*c+r];
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = a[i];
    return o ^ k;
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input int nr);
    logic [127:0] s;
    s = pt ^ rk[0];
    for (int r = 1; r <= nr; r++) s = aes_round(s, (r != nr), rk[r]);
    return s;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, b;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x] = b;
    end
  endtask

  // AES-128 key expansion into rk[0..10]; the unused slots get random filler.
  task automatic key_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    for (int r = 11; r < 16; r++) rk[r] = rand128();
  endtask

  // Behavioural round datapath: result appears lat_cfg cycles after each issue strobe.
  initial begin : dp_model
    logic [127:0] cd;
    logic         cm;
    model_v = 1'b0;
    model_d = 128'h0;
    forever begin
      @(negedge clk);
      if (dp_valid === 1'b1) begin
        cd = dp_data;
        cm = dp_mix_en;
        repeat (lat_cfg) @(posedge clk);
        #1;
        model_d = aes_round(cd, cm, rk_data);
        model_v = 1'b1;
        @(posedge clk);
        #1;
        model_v = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; blk_valid = 1'b0; res_ready = 1'b0; spur_v = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Drives one block from a negedge and observes it to the handshake; results go to the caller.
  task automatic run_block(input logic [127:0] pt, input int hold, input logic keep,
                           input logic [127:0] next_pt, input logic spur_done,
                           output logic [127:0] ct, output int lat_cyc, output int issues,
                           output int mix_bad, output int rdy_bad, output int stable_bad,
                           output int wait_cyc, output logic idle_ok, output logic timed_out);
    int   cyc;
    logic done;
    ct = 128'h0; lat_cyc = -1; issues = 0; mix_bad = 0; rdy_bad = 0; stable_bad = 0;
    wait_cyc = 0; idle_ok = 1'b0; timed_out = 1'b0;
    blk_data = pt;
    blk_valid = 1'b1;
    while (blk_ready !== 1'b1 && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (blk_ready !== 1'b1) begin
      timed_out = 1'b1;
      blk_valid = 1'b0;
      return;
    end
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (!keep) blk_valid = 1'b0;
      if (dp_valid === 1'b1) begin
        issues++;
        if (dp_mix_en !== (issues != nr_exp)) mix_bad++;
      end
      if (blk_ready !== 1'b0) rdy_bad++;
      if (res_valid === 1'b1) begin
        done = 1'b1;
        lat_cyc = cyc;
      end
    end
    if (!done) begin
      timed_out = 1'b1;
      return;
    end
    ct = res_data;
    for (int h = 0; h < hold; h++) begin
      if (spur_done && h == 0) begin
        spur_d = rand128();
        spur_v = 1'b1;
      end
      @(negedge clk);
      spur_v = 1'b0;
      if (res_data !== ct || res_valid !== 1'b1 || blk_ready !== 1'b0) stable_bad++;
    end
    if (keep) blk_data = next_pt;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    idle_ok = (blk_ready === 1'b1 && busy === 1'b0 && res_valid === 1'b0);
  endtask

  logic [127:0] ct, exp_ct;
  int           lat_cyc, issues, mix_bad, rdy_bad, stable_bad, wait_cyc;
  logic         idle_ok, to;

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++; if ({blk_ready, busy, dp_valid, res_valid, err} !== 5'b10000) begin n_miss++; $display("FAIL reset_flags got %b want 10000", {blk_ready, busy, dp_valid, res_valid, err}); end
    n_vec++; if (rk_idx !== 4'd0) begin n_miss++; $display("FAIL reset_rk_idx got %0d want 0", rk_idx); end
    n_vec++; if (res_data !== 128'h0 || dp_data !== 128'h0) begin n_miss++; $display("FAIL reset_state got %h want 0", res_data); end
    reset = 1'b1;
  endtask

  task automatic test_fips();
    do_reset();
    key_expand(FIPS_KEY);
    lat_cfg = 1; nr_exp = 10;
    run_block(FIPS_PT, 0, 1'b0, 128'h0, 1'b0, ct, lat_cyc, issues, mix_bad, rdy_bad, stable_bad, wait_cyc, idle_ok, to);
    n_vec++; if (to) begin n_miss++; $display("FAIL fips_timeout got timeout want completion"); end
    n_vec++; if (ct !== FIPS_CT) begin n_miss++; $display("FAIL fips_ct got %h want %h", ct, FIPS_CT); end
    n_vec++; if (lat_cyc != 21) begin n_miss++; $display("FAIL fips_latency got %0d want 21", lat_cyc); end
    n_vec++; if (issues != 10 || mix_bad != 0) begin n_miss++; $display("FAIL fips_issues got %0d/%0d want 10/0", issues, mix_bad); end
    n_vec++; if (!idle_ok || err !== 1'b0) begin n_miss++; $display("FAIL fips_idle got %b/%b want 1/0", idle_ok, err); end
  endtask

  task automatic test_stall();
    do_reset();
    key_expand(FIPS_KEY);
    lat_cfg = 4; nr_exp = 10;
    run_block(FIPS_PT, 5, 1'b0, 128'h0, 1'b0, ct, lat_cyc, issues, mix_bad, rdy_bad, stable_bad, wait_cyc, idle_ok, to);
    n_vec++; if (ct !== FIPS_CT || to) begin n_miss++; $display("FAIL stall_ct got %h want %h", ct, FIPS_CT); end
    n_vec++; if (lat_cyc != 51) begin n_miss++; $display("FAIL stall_latency got %0d want 51", lat_cyc); end
    n_vec++; if (stable_bad != 0 || rdy_bad != 0) begin n_miss++; $display("FAIL stall_hold got %0d/%0d want 0/0", stable_bad, rdy_bad); end
    n_vec++; if (!idle_ok) begin n_miss++; $display("FAIL stall_idle got %b want 1", idle_ok); end
  endtask

  task automatic test_spurious();
    logic [127:0] pt;
    do_reset();
    key_expand(rand128());
    lat_cfg = 2; nr_exp = 10;
    spur_d = rand128();
    spur_v = 1'b1;
    @(negedge clk);
    spur_v = 1'b0;
    n_vec++; if (err !== 1'b1 || blk_ready !== 1'b1 || busy !== 1'b0) begin n_miss++; $display("FAIL spur_idle got err=%b rdy=%b busy=%b want 1/1/0", err, blk_ready, busy); end
    pt = rand128();
    exp_ct = ref_encrypt(pt, 10);
    run_block(pt, 3, 1'b0, 128'h0, 1'b1, ct, lat_cyc, issues, mix_bad, rdy_bad, stable_bad, wait_cyc, idle_ok, to);
    n_vec++; if (ct !== exp_ct || to) begin n_miss++; $display("FAIL spur_ct got %h want %h", ct, exp_ct); end
    n_vec++; if (stable_bad != 0 || !idle_ok) begin n_miss++; $display("FAIL spur_done got %0d/%b want 0/1", stable_bad, idle_ok); end
    n_vec++; if (err !== 1'b1) begin n_miss++; $display("FAIL spur_sticky got %b want 1", err); end
  endtask

  task automatic test_reset_mid();
    int cnt;
    logic [127:0] pt;
    do_reset();
    key_expand(rand128());
    lat_cfg = 4; nr_exp = 10;
    @(negedge clk);
    blk_data = rand128();
    blk_valid = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    cnt = 0;
    while (!(dp_valid === 1'b1 && rk_idx === 4'd5) && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    @(negedge clk);
    n_vec++; if (rk_idx !== 4'd5 || busy !== 1'b1 || dp_valid !== 1'b0) begin n_miss++; $display("FAIL midrst_wait5 got idx=%0d busy=%b want 5/1", rk_idx, busy); end
    reset = 1'b0;
    #1;
    n_vec++; if ({blk_ready, busy, dp_valid, res_valid, err} !== 5'b10000 || rk_idx !== 4'd0) begin n_miss++; $display("FAIL midrst_flags got %b idx=%0d want 10000 idx=0", {blk_ready, busy, dp_valid, res_valid, err}, rk_idx); end
    n_vec++; if (res_data !== 128'h0) begin n_miss++; $display("FAIL midrst_state got %h want 0", res_data); end
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    n_vec++; if (err !== 1'b1 || busy !== 1'b0) begin n_miss++; $display("FAIL midrst_stale got err=%b busy=%b want 1/0", err, busy); end
    do_reset();
    lat_cfg = 1;
    pt = rand128();
    exp_ct = ref_encrypt(pt, 10);
    run_block(pt, 0, 1'b0, 128'h0, 1'b0, ct, lat_cyc, issues, mix_bad, rdy_bad, stable_bad, wait_cyc, idle_ok, to);
    n_vec++; if (ct !== exp_ct || to || err !== 1'b0) begin n_miss++; $display("FAIL midrst_after got %h want %h", ct, exp_ct); end
  endtask

  task automatic test_random();
    logic [127:0] pt;
    int hold;
    for (int b = 0; b < 4; b++) begin
      do_reset();
      key_expand(rand128());
      lat_cfg = $urandom_range(5, 1);
      hold = $urandom_range(3, 0);
      nr_exp = 10;
      pt = rand128();
      exp_ct = ref_encrypt(pt, 10);
      run_block(pt, hold, 1'b0, 128'h0, 1'b0, ct, lat_cyc, issues, mix_bad, rdy_bad, stable_bad, wait_cyc, idle_ok, to);
      n_vec++; if (ct !== exp_ct || to) begin n_miss++; $display("FAIL rand_ct[%0d] got %h want %h", b, ct, exp_ct); end
      n_vec++; if (lat_cyc != 1 + 10 * (lat_cfg + 1)) begin n_miss++; $display("FAIL rand_latency[%0d] got %0d want %0d", b, lat_cyc, 1 + 10 * (lat_cfg + 1)); end
      n_vec++; if (issues != 10 || mix_bad != 0 || stable_bad != 0 || !idle_ok) begin n_miss++; $display("FAIL rand_proto[%0d] got %0d/%0d/%0d/%b want 10/0/0/1", b, issues, mix_bad, stable_bad, idle_ok); end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] pt1, pt2, e1, e2;
    do_reset();
    key_expand(rand128());
    lat_cfg = 1; nr_exp = 10;
    pt1 = rand128(); pt2 = rand128();
    e1 = ref_encrypt(pt1, 10);
    e2 = ref_encrypt(pt2, 10);
    run_block(pt1, 1, 1'b1, pt2, 1'b0, ct, lat_cyc, issues, mix_bad, rdy_bad, stable_bad, wait_cyc, idle_ok, to);
    n_vec++; if (ct !== e1 || to || !idle_ok || stable_bad != 0) begin n_miss++; $display("FAIL b2b_first got %h idle=%b want %h idle=1", ct, idle_ok, e1); end
    run_block(pt2, 0, 1'b0, 128'h0, 1'b0, ct, lat_cyc, issues, mix_bad, rdy_bad, stable_bad, wait_cyc, idle_ok, to);
    n_vec++; if (wait_cyc != 0 || lat_cyc != 21) begin n_miss++; $display("FAIL b2b_accept got wait=%0d lat=%0d want 0/21", wait_cyc, lat_cyc); end
    n_vec++; if (ct !== e2 || to) begin n_miss++; $display("FAIL b2b_second got %h want %h", ct, e2); end
  endtask

`ifdef AES_ROUND_CTRL_KEYLEN_EN
  task automatic test_keylen();
    logic [127:0] pt;
    logic [1:0]   kls [3];
    int           nrs [3];
    logic         errs [3];
    kls[0] = 2'b10; nrs[0] = 14; errs[0] = 1'b0;
    kls[1] = 2'b01; nrs[1] = 12; errs[1] = 1'b0;
    kls[2] = 2'b11; nrs[2] = 10; errs[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      for (int r = 0; r < 16; r++) rk[r] = rand128();
      lat_cfg = 1;
      nr_exp = nrs[k];
      key_len = kls[k];
      pt = rand128();
      exp_ct = ref_encrypt(pt, nrs[k]);
      run_block(pt, 0, 1'b0, 128'h0, 1'b0, ct, lat_cyc, issues, mix_bad, rdy_bad, stable_bad, wait_cyc, idle_ok, to);
      n_vec++; if (issues != nrs[k] || mix_bad != 0) begin n_miss++; $display("FAIL keylen_issues[%0d] got %0d/%0d want %0d/0", k, issues, mix_bad, nrs[k]); end
      n_vec++; if (ct !== exp_ct || to) begin n_miss++; $display("FAIL keylen_ct[%0d] got %h want %h", k, ct, exp_ct); end
      n_vec++; if (err !== errs[k]) begin n_miss++; $display("FAIL keylen_err[%0d] got %b want %b", k, err, errs[k]); end
    end
    key_len = 2'b00;
  endtask
`endif

  initial begin
    reset = 1'b0; blk_valid = 1'b0; blk_data = 128'h0; res_ready = 1'b0;
    spur_v = 1'b0; spur_d = 128'h0;
`ifdef AES_ROUND_CTRL_KEYLEN_EN
    key_len = 2'b00;
`endif
    for (int r = 0; r < 16; r++) rk[r] = 128'h0;
    build_sbox();
    test_reset();
    test_fips();
    test_stall();
    test_spurious();
    test_reset_mid();
    test_random();
    test_back_to_back();
`ifdef AES_ROUND_CTRL_KEYLEN_EN
    test_keylen();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Sequences one AES-128 encryption block through the external round datapath (SubBytes -> ShiftRows -> MixColumns -> AddRoundKey), one round per issue.
- Holds the 128-bit state register and performs the initial AddRoundKey (round 0).
- Issues rounds 1..NR, requests round keys by index, and drives the MixColumns enable low in the final round.
- Sits between the block-level valid/ready interface and the round datapath / key schedule.

Parameters:
- DATA_W, 128, state/data width in bits.
- NR, 10, number of rounds (round 0 excluded).
- RND_W, 4, width of the round index; must satisfy 2^RND_W > NR.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- blk_valid  in  1  input block valid
- blk_ready  out  1  controller can accept a block
- blk_data  in  DATA_W  plaintext block
- rk_idx  out  RND_W  round-key index to key schedule, combinational from state
- rk_data  in  DATA_W  round key for rk_idx, valid same cycle
- dp_valid  out  1  one-cycle round issue strobe to datapath
- dp_data  out  DATA_W  state fed to datapath
- dp_mix_en  out  1  1 = apply MixColumns; 0 in final round
- dp_valid_in  in  1  datapath result valid
- dp_data_in  in  DATA_W  datapath round result
- res_valid  out  1  ciphertext valid
- res_ready  in  1  downstream accepts ciphertext
- res_data  out  DATA_W  ciphertext, equals state register
- busy  out  1  high in any state except IDLE
- err  out  1  sticky protocol error

Behaviour:
- Reset (async, reset=0): state=IDLE, round counter=0, state register=0, err=0. dp_valid=0, res_valid=0, blk_ready=1 (IDLE decode), busy=0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - blk_ready=1, rk_idx=0.
  - On blk_valid: state_reg <= blk_data ^ rk_data; rnd <= 1; go to ISSUE.
- ISSUE:
  - dp_valid=1 for exactly one cycle; dp_data=state_reg; rk_idx=rnd; dp_mix_en=(rnd!=NR).
  - Go to WAIT.
- WAIT:
  - rk_idx=rnd, held stable for the datapath's AddRoundKey.
  - On dp_valid_in: state_reg <= dp_data_in.
  - If rnd==NR, go to DONE; else rnd <= rnd+1 and go to ISSUE.
  - Datapath latency L>=1 is arbitrary; the controller waits indefinitely.
- DONE:
  - res_valid=1; res_data=state_reg, held stable while res_ready=0.
  - On res_ready: go to IDLE, rnd <= 0.
  - blk_ready stays 0 until IDLE is re-entered; there is no accept on the same cycle as handoff.
- Latency:
  - Accept at cycle 0 -> res_valid at cycle 1+NR*(L+1).
  - With L=1, NR=10: cycle 21.
- Throughput: one block in flight; no overlap.
- Error handling: dp_valid_in while not in WAIT sets err (sticky until reset); the data is ignored and the FSM is unaffected.
- dp_valid_in in the same cycle as dp_valid (ISSUE) is treated as an error (L>=1 required).
- Round counter never exceeds NR. No wrap: it is reset to 0 on leaving DONE.
- Reset mid-operation: immediate return to IDLE; the in-flight block is discarded. Datapath results arriving after reset with the FSM in IDLE set err.

Optional Feature:
- Macro AES_ROUND_CTRL_KEYLEN_EN.
- Defined:
  - Adds input key_len[1:0]: 00 -> 10 rounds, 01 -> 12, 10 -> 14, 11 -> reserved.
  - key_len is sampled at block accept and held for the block.
  - Reserved value sets err and uses 10 rounds.
  - RND_W must be >= 4; the final-round compare uses the sampled value.
- Undefined: the port is absent and the round count is fixed at NR.

Decomposition:
- Shared package aes_pkg holds:
  - state enum (IDLE/ISSUE/WAIT/DONE)
  - AES_NR_128/192/256 constants (10/12/14)
  - key_len encoding constants
  - default DATA_W
- Flat module; no sub-module needed.
- The round-0 XOR stays inline.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734; behavioural datapath with L=1 -> res_data 3925841d02dc09fbdc118597196a0b32 at cycle 21; dp_mix_en=0 only on the 10th issue.
- Same vector with L=4 and res_ready held low 5 cycles after res_valid -> res_valid at cycle 51; res_data stable; blk_ready=0 throughout; return to IDLE one cycle after res_ready.
- Spurious dp_valid_in in IDLE and in DONE -> err=1 and stays 1; ciphertext still correct.
- Reset asserted in WAIT of round 5 -> all outputs reach reset values immediately; new block after release produces correct ciphertext.
- Back-to-back blocks with blk_valid held high -> second accept exactly one cycle after the first res_ready handshake.
- With AES_ROUND_CTRL_KEYLEN_EN: key_len=10 -> 14 dp_valid pulses, dp_mix_en low on the 14th; key_len=11 -> err=1, 10 rounds.
